// File: rtl/flash_arb_pkg.sv
// Shared definitions for the flash arbiter.
//   arb_state_e    : arbiter FSM state encoding (IDLE, ISSUE, WAIT, DONE)
//   FL_FLOW_*      : FL_FLOW direction encoding
//   PORT_A/PORT_B  : grant index of each requester
//   req_t          : latched request fields of one port
package flash_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    localparam logic FL_FLOW_READ  = 1'b1;
    localparam logic FL_FLOW_WRITE = 1'b0;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    // Direction code driven on FL_FLOW for a given write flag.
    function automatic logic flow_of(input logic wr);
        return wr ? FL_FLOW_WRITE : FL_FLOW_READ;
    endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the flash controller.
//   a_* / b_*  : requester handshake (req, wr, addr, data in; done, err out)
//   rdata      : read data returned with done
//   busy       : arbiter not idle
//   fl_*       : flash controller port (addr, data, trg, flow out; status, rdata in)
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus flash controller)
interface flash_arbiter_if;

    logic       a_req;
    logic       a_wr;
    logic [7:0] a_addr;
    logic [7:0] a_data;
    logic       a_done;
    logic       a_err;

    logic       b_req;
    logic       b_wr;
    logic [7:0] b_addr;
    logic [7:0] b_data;
    logic       b_done;
    logic       b_err;

    logic [7:0] rdata;
    logic       busy;

    logic [7:0] fl_addr;
    logic [7:0] fl_data;
    logic       fl_trg;
    logic       fl_flow;
    logic       fl_status;
    logic [7:0] fl_rdata;

    modport slave (
        input  a_req, a_wr, a_addr, a_data,
        input  b_req, b_wr, b_addr, b_data,
        input  fl_status, fl_rdata,
        output a_done, a_err, b_done, b_err,
        output rdata, busy,
        output fl_addr, fl_data, fl_trg, fl_flow
    );

    modport master (
        output a_req, a_wr, a_addr, a_data,
        output b_req, b_wr, b_addr, b_data,
        output fl_status, fl_rdata,
        input  a_done, a_err, b_done, b_err,
        input  rdata, busy,
        input  fl_addr, fl_data, fl_trg, fl_flow
    );

endinterface

// File: rtl/flash_arb_watchdog.sv
// Timeout counter for the arbiter WAIT state.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clr     : zero the counter (takes priority over en)
//   en      : count one cycle
//   expired : counter has reached TIMEOUT_CYCLES-1
module flash_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LastCount = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            // Holding at the limit keeps expired stable if en lingers.
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LastCount);

endmodule

// File: rtl/flash_arbiter.sv
// Two-port arbiter in front of the single flash controller port.
// Port A (command manager) and port B (display reader) each hold req until
// their done pulse; one transaction at a time is issued with a one-cycle
// fl_trg, completed on fl_status or on watchdog timeout (err=1).
//   clk_50mhz : system clock
//   rst       : synchronous active-high reset
//   bus       : flash_arbiter_if.slave (requester and flash signals)
// Build option: define FLASH_ARB_RR_EN for round-robin arbitration;
// otherwise port A has fixed priority over port B.
// All outputs come straight from flops.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic            clk_50mhz,
    input logic            rst,
    flash_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    // Latched grant index; in round-robin builds it is also the last-granted pointer.
    logic       grant_q, grant_d;
    logic       pick;

    logic [7:0] fl_addr_q, fl_addr_d;
    logic [7:0] fl_data_q, fl_data_d;
    logic       fl_flow_q, fl_flow_d;
    logic       fl_trg_q, fl_trg_d;
    logic       busy_q, busy_d;
    logic [7:0] rdata_q, rdata_d;
    logic       a_done_q, a_done_d;
    logic       b_done_q, b_done_d;
    logic       a_err_q, a_err_d;
    logic       b_err_q, b_err_d;

    req_t req_a, req_b, req_sel;

    logic wd_clr, wd_en, wd_expired;

    assign req_a = '{wr: bus.a_wr, addr: bus.a_addr, data: bus.a_data};
    assign req_b = '{wr: bus.b_wr, addr: bus.b_addr, data: bus.b_data};

    // Counter is zeroed during ISSUE so it reads 0 in the first WAIT cycle.
    assign wd_clr = (state_q == StIssue);
    assign wd_en  = (state_q == StWait);

    flash_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk_50mhz),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
`ifdef FLASH_ARB_RR_EN
        if (bus.a_req && bus.b_req) begin
            pick = (grant_q == PORT_A) ? PORT_B : PORT_A;
        end else begin
            pick = bus.a_req ? PORT_A : PORT_B;
        end
`else
        pick = bus.a_req ? PORT_A : PORT_B;
`endif
    end

    assign req_sel = (pick == PORT_A) ? req_a : req_b;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        fl_addr_d = fl_addr_q;
        fl_data_d = fl_data_q;
        fl_flow_d = fl_flow_q;
        fl_trg_d  = 1'b0;
        rdata_d   = rdata_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.a_req || bus.b_req) begin
                    state_d   = StIssue;
                    grant_d   = pick;
                    fl_addr_d = req_sel.addr;
                    fl_data_d = req_sel.data;
                    fl_flow_d = flow_of(req_sel.wr);
                    fl_trg_d  = 1'b1;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // fl_status wins over a coincident timeout.
                if (bus.fl_status || wd_expired) begin
                    state_d = StDone;
                    if (grant_q == PORT_A) begin
                        a_done_d = 1'b1;
                        a_err_d  = !bus.fl_status;
                    end else begin
                        b_done_d = 1'b1;
                        b_err_d  = !bus.fl_status;
                    end
                    if (bus.fl_status && (fl_flow_q == FL_FLOW_READ)) begin
                        rdata_d = bus.fl_rdata;
                    end
                end
            end
            StDone: begin
                state_d   = StIdle;
                fl_flow_d = FL_FLOW_READ;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= PORT_B;
            fl_addr_q <= '0;
            fl_data_q <= '0;
            fl_flow_q <= FL_FLOW_READ;
            fl_trg_q  <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            fl_addr_q <= fl_addr_d;
            fl_data_q <= fl_data_d;
            fl_flow_q <= fl_flow_d;
            fl_trg_q  <= fl_trg_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
        end
    end

    assign bus.fl_addr = fl_addr_q;
    assign bus.fl_data = fl_data_q;
    assign bus.fl_flow = fl_flow_q;
    assign bus.fl_trg  = fl_trg_q;
    assign bus.busy    = busy_q;
    assign bus.rdata   = rdata_q;
    assign bus.a_done  = a_done_q;
    assign bus.b_done  = b_done_q;
    assign bus.a_err   = a_err_q;
    assign bus.b_err   = b_err_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: requester/flash model driven from a
// single process, expected transactions queued when requests are raised and
// popped when a done pulse appears.
module tb_flash_arbiter;
    import flash_arb_pkg::*;

    localparam int unsigned ToCycles = 8;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    flash_arbiter_if bus ();

    flash_arbiter #(
        .TIMEOUT_CYCLES(ToCycles)
    ) dut (
        .clk_50mhz(clk),
        .rst      (rst),
        .bus      (bus)
    );

    typedef struct {
        logic       port;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    logic grant_log[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    int last_trg_cyc = -1;
    int trg_count = 0;
    logic prev_trg = 1'b0;
    logic chk_spacing = 1'b0;

    int fl_delay = 0;  // cycles from fl_trg to fl_status; 0 = never answer
    int fl_cd = 0;
    logic [7:0] rd_val = 8'h00;
    logic stray = 1'b0;
    logic [7:0] model_rdata = 8'h00;

    int left[2];
    int idx[2];
    logic [7:0] abase[2];
    logic [7:0] dbase[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) bus.a_req = v;
        else bus.b_req = v;
    endtask

    task automatic set_ad(input int p, input logic [7:0] addr, input logic [7:0] data);
        if (p == 0) begin
            bus.a_addr = addr;
            bus.a_data = data;
        end else begin
            bus.b_addr = addr;
            bus.b_data = data;
        end
    endtask

    task automatic start_port(input int p, input logic wr, input logic [7:0] addr,
                              input logic [7:0] data, input int count);
        if (p == 0) bus.a_wr = wr;
        else bus.b_wr = wr;
        abase[p] = addr;
        dbase[p] = data;
        idx[p] = 0;
        left[p] = count;
        set_ad(p, addr, data);
        set_req(p, 1'b1);
    endtask

    task automatic push_exp(input logic p, input logic wr, input logic [7:0] addr,
                            input logic [7:0] data, input logic err, input logic [7:0] rd);
        exp_t e;
        e.port = p;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        e.err = err;
        e.rdata = (!wr && !err) ? rd : model_rdata;
        model_rdata = e.rdata;
        exp_q.push_back(e);
    endtask

    // Requester reaction to its own done: next transaction or drop req.
    task automatic advance(input int p);
        if (left[p] > 0) left[p]--;
        if (left[p] == 0) begin
            set_req(p, 1'b0);
        end else begin
            idx[p]++;
            set_ad(p, abase[p] + 8'(idx[p]), dbase[p] + 8'(idx[p]));
        end
    endtask

    task automatic tick();
        exp_t e;
        logic status;
        @(negedge clk);
        cyc++;
        if (bus.fl_trg) begin
            trg_count++;
            check_eq("trg_width", prev_trg, 1'b0);
            check_eq("busy_issue", bus.busy, 1'b1);
            if (exp_q.size() == 0) begin
                check_eq("spurious_trg", 1'b1, 1'b0);
            end else begin
                e = exp_q[0];
                check_eq("fl_addr", bus.fl_addr, e.addr);
                check_eq("fl_data", bus.fl_data, e.data);
                check_eq("fl_flow", bus.fl_flow, e.wr ? 1'b0 : 1'b1);
            end
            if (chk_spacing && last_trg_cyc >= 0) check_eq("trg_spacing", cyc - last_trg_cyc, 4);
            last_trg_cyc = cyc;
        end
        prev_trg = bus.fl_trg;

        if (bus.a_done || bus.b_done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("done_port", bus.b_done, e.port);
                check_eq("done_onehot", bus.a_done & bus.b_done, 1'b0);
                check_eq("err", e.port ? bus.b_err : bus.a_err, e.err);
                check_eq("rdata", bus.rdata, e.rdata);
                grant_log.push_back(bus.b_done);
                last_done_cyc = cyc;
            end
        end
        if (bus.a_done) advance(0);
        if (bus.b_done) advance(1);

        // Flash controller model.
        status = 1'b0;
        if (fl_cd > 0) begin
            fl_cd--;
            if (fl_cd == 0) status = 1'b1;
        end
        if (bus.fl_trg && fl_delay > 0) fl_cd = fl_delay;
        bus.fl_status = status | stray;
        bus.fl_rdata = rd_val;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_trg"}, bus.fl_trg, 1'b0);
        check_eq({tag, "_flow"}, bus.fl_flow, 1'b1);
        check_eq({tag, "_fladdr"}, bus.fl_addr, 8'h00);
        check_eq({tag, "_fldata"}, bus.fl_data, 8'h00);
        check_eq({tag, "_rdata"}, bus.rdata, 8'h00);
        check_eq({tag, "_done"}, {bus.a_done, bus.b_done}, 2'b00);
        check_eq({tag, "_err"}, {bus.a_err, bus.b_err}, 2'b00);
    endtask

    initial begin
        int req_cyc;
        int trg0;
        logic exp_order[6];

        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = 8'h00; bus.a_data = 8'h00;
        bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_addr = 8'h00; bus.b_data = 8'h00;
        bus.fl_status = 1'b0;
        bus.fl_rdata = 8'h00;
        left[0] = 0; left[1] = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset("reset");

        // Single write on A, flash answers 5 cycles after the trigger.
        rd_val = 8'hEE;
        fl_delay = 5;
        start_port(0, 1'b1, 8'h12, 8'hA5, 1);
        push_exp(1'b0, 1'b1, 8'h12, 8'hA5, 1'b0, 8'h00);
        req_cyc = cyc;
        trg0 = trg_count;
        drain(40);
        check_eq("wr_trg_cycle", last_trg_cyc - req_cyc, 1);
        check_eq("wr_trg_count", trg_count - trg0, 1);
        check_eq("wr_done_latency", last_done_cyc - req_cyc, 7);
        check_eq("idle_flow", bus.fl_flow, 1'b1);
        check_eq("idle_addr_held", bus.fl_addr, 8'h12);

        // Read on B.
        rd_val = 8'h3C;
        fl_delay = 2;
        start_port(1, 1'b0, 8'h40, 8'h00, 1);
        push_exp(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h3C);
        req_cyc = cyc;
        drain(40);
        check_eq("rd_done_latency", last_done_cyc - req_cyc, 4);

        // Both ports request three transactions each, minimum flash latency.
        rd_val = 8'h77;
        fl_delay = 1;
        chk_spacing = 1'b1;
        last_trg_cyc = -1;
        grant_log.delete();
        start_port(0, 1'b1, 8'h20, 8'hA0, 3);
        start_port(1, 1'b0, 8'h60, 8'hB0, 3);
`ifdef FLASH_ARB_RR_EN
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 1'b1, 8'h20 + 8'(i), 8'hA0 + 8'(i), 1'b0, 8'h00);
            push_exp(1'b1, 1'b0, 8'h60 + 8'(i), 8'hB0 + 8'(i), 1'b0, 8'h77);
            exp_order[2*i] = 1'b0;
            exp_order[2*i+1] = 1'b1;
        end
`else
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 1'b1, 8'h20 + 8'(i), 8'hA0 + 8'(i), 1'b0, 8'h00);
            exp_order[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b1, 1'b0, 8'h60 + 8'(i), 8'hB0 + 8'(i), 1'b0, 8'h77);
            exp_order[3+i] = 1'b1;
        end
`endif
        drain(200);
        chk_spacing = 1'b0;
        check_eq("order_len", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check_eq("grant_order", grant_log[i], exp_order[i]);
        end

        // Timeout: flash never answers.
        fl_delay = 0;
        start_port(0, 1'b0, 8'h55, 8'h00, 1);
        push_exp(1'b0, 1'b0, 8'h55, 8'h00, 1'b1, 8'h00);
        req_cyc = cyc;
        drain(60);
        check_eq("timeout_latency", last_done_cyc - req_cyc, ToCycles + 2);

        // Stale status while idle must not produce a done.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("stray_busy", bus.busy, 1'b0);

        // Reset in the middle of WAIT drops the transaction.
        fl_delay = 0;
        start_port(0, 1'b1, 8'h99, 8'h66, 1);
        push_exp(1'b0, 1'b1, 8'h99, 8'h66, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        check_eq("wait_busy", bus.busy, 1'b1);
        exp_q.delete();
        model_rdata = 8'h00;
        left[0] = 0;
        rst = 1'b1;
        bus.a_req = 1'b0;
        tick();
        rst = 1'b0;
        check_reset("midrst");
        for (int i = 0; i < 6; i++) tick();
        check_eq("post_rst_idle", bus.busy, 1'b0);

        // Fresh request after the reset completes normally.
        rd_val = 8'h5E;
        fl_delay = 1;
        start_port(0, 1'b0, 8'h31, 8'h00, 1);
        push_exp(1'b0, 1'b0, 8'h31, 8'h00, 1'b0, 8'h5E);
        req_cyc = cyc;
        drain(40);
        check_eq("post_rst_latency", last_done_cyc - req_cyc, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
